// File: rtl/cacheline_pkg.sv
// Shared types and constants for the cache-line burst adaptor.
//   ca_state_e : adaptor FSM states
//   CA_*       : default geometry (256-bit line, 64-bit beats, 32-bit address)
//   BEATS, CNT_W, LINE_OFF_W, BEAT_OFF_W : derived from the default geometry
//   beat_slot  : line slot touched by the beat with a given counter value
//                when a burst starts at beat `start` (wrap order).
package cacheline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ca_state_e;

    localparam int CA_LINE_W  = 256;
    localparam int CA_BEAT_W  = 64;
    localparam int CA_ADDR_W  = 32;

    localparam int BEATS      = CA_LINE_W / CA_BEAT_W;
    localparam int CNT_W      = $clog2(BEATS);
    localparam int LINE_OFF_W = $clog2(CA_LINE_W / 8);
    localparam int BEAT_OFF_W = $clog2(CA_BEAT_W / 8);

    // Wrap-order slot: (start + cnt) mod beats.
    function automatic int unsigned beat_slot(input int unsigned start,
                                              input int unsigned cnt,
                                              input int unsigned beats);
        return (start + cnt) % beats;
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat counter for one burst.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : synchronous clear (has priority over i_en)
//   i_en       : advance by one beat
//   o_cnt      : current beat index, wraps to 0 after the last beat
//   o_last     : o_cnt is the final beat of the burst
module beat_counter
    import cacheline_pkg::*;
#(
    parameter int N_BEATS = BEATS,
    parameter int W       = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_last ? '0 : r_cnt + W'(1);
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == W'(N_BEATS - 1));

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Cache-line <-> pmem burst adaptor.
// Turns one LINE_W-bit line read/write from the cache into a BEATS-beat
// burst of BEAT_W-bit transfers and reassembles read beats into a line.
//   clk, rst_n          : clock, async active-low reset
//   line_addr/read/write/wdata : cache request (sampled only in IDLE)
//   line_rdata, line_resp, busy : fill line, one-cycle completion, FSM not IDLE
//   burst_addr/read/write/wdata : pmem burst request, held for whole burst
//   burst_rdata, burst_resp     : pmem beat return / beat accept
// Optional: define CA_CRIT_WORD_FIRST_EN to issue reads starting at the
// requested beat (wrap order); otherwise every burst starts at beat 0.
module cacheline_burst_adaptor
    import cacheline_pkg::*;
#(
    parameter int LINE_W = CA_LINE_W,
    parameter int BEAT_W = CA_BEAT_W,
    parameter int ADDR_W = CA_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic              busy,
    output logic [ADDR_W-1:0] burst_addr,
    output logic              burst_read,
    output logic              burst_write,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
);

    localparam int NBEATS      = LINE_W / BEAT_W;
    localparam int NCNT_W      = $clog2(NBEATS);
    localparam int NLINE_OFF_W = $clog2(LINE_W / 8);
    localparam int NBEAT_OFF_W = $clog2(BEAT_W / 8);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << NLINE_OFF_W) - 1);
    localparam logic [ADDR_W-1:0] BEAT_MASK = ~ADDR_W'((1 << NBEAT_OFF_W) - 1);

    ca_state_e                       r_state;
    logic [ADDR_W-1:0]               r_burst_addr;
    logic [NBEATS-1:0][BEAT_W-1:0]   r_wdata;
    logic [NBEATS-1:0][BEAT_W-1:0]   r_rdata;
    logic                            r_line_resp;
    logic                            r_burst_read;
    logic                            r_burst_write;

    logic [NCNT_W-1:0]               w_cnt;
    logic [NCNT_W-1:0]               w_slot;
    logic                            w_last;
    logic                            w_active;
    logic                            w_beat;

    assign w_active = (r_state == READ) || (r_state == WRITE);
    // burst_resp outside a burst must not move the counter.
    assign w_beat   = w_active && burst_resp;

    beat_counter #(
        .N_BEATS (NBEATS),
        .W       (NCNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (r_state == IDLE),
        .i_en   (w_beat),
        .o_cnt  (w_cnt),
        .o_last (w_last)
    );

`ifdef CA_CRIT_WORD_FIRST_EN
    // First beat returned by pmem for the current read.
    logic [NCNT_W-1:0] r_start;
    assign w_slot = NCNT_W'(beat_slot(32'(r_start), 32'(w_cnt), NBEATS));
`else
    assign w_slot = NCNT_W'(beat_slot(0, 32'(w_cnt), NBEATS));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_burst_addr  <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_line_resp   <= 1'b0;
            r_burst_read  <= 1'b0;
            r_burst_write <= 1'b0;
`ifdef CA_CRIT_WORD_FIRST_EN
            r_start       <= '0;
`endif
        end else begin
            r_line_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Write wins a tie; a held read is picked up after DONE.
                    if (line_write) begin
                        r_state       <= WRITE;
                        r_burst_write <= 1'b1;
                        r_burst_addr  <= line_addr & LINE_MASK;
                        r_wdata       <= line_wdata;
`ifdef CA_CRIT_WORD_FIRST_EN
                        r_start       <= '0;
`endif
                    end else if (line_read) begin
                        r_state      <= READ;
                        r_burst_read <= 1'b1;
`ifdef CA_CRIT_WORD_FIRST_EN
                        r_burst_addr <= line_addr & BEAT_MASK;
                        r_start      <= line_addr[NLINE_OFF_W-1:NBEAT_OFF_W];
`else
                        r_burst_addr <= line_addr & LINE_MASK;
`endif
                    end
                end
                READ: begin
                    if (burst_resp) begin
                        r_rdata[w_slot] <= burst_rdata;
                        if (w_last) begin
                            r_state      <= DONE;
                            r_burst_read <= 1'b0;
                            r_line_resp  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (burst_resp && w_last) begin
                        r_state       <= DONE;
                        r_burst_write <= 1'b0;
                        r_line_resp   <= 1'b1;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign line_rdata  = r_rdata;
    assign line_resp   = r_line_resp;
    assign busy        = (r_state != IDLE);
    assign burst_addr  = r_burst_addr;
    assign burst_read  = r_burst_read;
    assign burst_write = r_burst_write;
    assign burst_wdata = (r_state == WRITE) ? r_wdata[w_cnt] : '0;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
module tb_cacheline_burst_adaptor;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [31:0]   line_addr = '0;
    logic          line_read = 1'b0;
    logic          line_write = 1'b0;
    logic [255:0]  line_wdata = '0;
    logic [255:0]  line_rdata;
    logic          line_resp;
    logic          busy;
    logic [31:0]   burst_addr;
    logic          burst_read;
    logic          burst_write;
    logic [63:0]   burst_wdata;
    logic [63:0]   burst_rdata = '0;
    logic          burst_resp = 1'b0;

    cacheline_burst_adaptor dut (
        .clk(clk), .rst_n(rst_n),
        .line_addr(line_addr), .line_read(line_read), .line_write(line_write),
        .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
        .busy(busy), .burst_addr(burst_addr), .burst_read(burst_read),
        .burst_write(burst_write), .burst_wdata(burst_wdata),
        .burst_rdata(burst_rdata), .burst_resp(burst_resp)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct { logic [31:0] addr; bit wr; logic [63:0] wdata; } beat_t;
    typedef struct { logic [255:0] rdata; int cyc; } line_t;
    beat_t bq[$];
    line_t lq[$];
    logic [255:0] model_rdata = '0;

    function automatic logic [31:0] raddr(input logic [31:0] a);
`ifdef CA_CRIT_WORD_FIRST_EN
        return a & ~32'h7;
`else
        return a & ~32'h1F;
`endif
    endfunction

    function automatic int rstart(input logic [31:0] a);
`ifdef CA_CRIT_WORD_FIRST_EN
        return int'(a[4:3]);
`else
        return 0;
`endif
    endfunction

    task automatic push_write(input logic [31:0] a, input logic [255:0] wd);
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b.addr = a & ~32'h1F; b.wr = 1'b1; b.wdata = wd[i*64 +: 64];
            bq.push_back(b);
        end
        lq.push_back('{rdata: model_rdata, cyc: -1});
    endtask

    task automatic push_read(input logic [31:0] a, input logic [255:0] ln, input int ecyc);
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b.addr = raddr(a); b.wr = 1'b0; b.wdata = '0;
            bq.push_back(b);
        end
        model_rdata = ln;
        lq.push_back('{rdata: ln, cyc: ecyc});
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (burst_read || burst_write)
                chk("no_rd_wr_overlap", {255'd0, burst_read && burst_write}, 256'd0);
            if (burst_write && bq.size() > 0)
                chk("wdata_held", {192'd0, burst_wdata}, {192'd0, bq[0].wdata});
            if ((burst_read || burst_write) && burst_resp) begin
                if (bq.size() == 0) chk("unexpected_beat", 256'd1, 256'd0);
                else begin
                    beat_t b;
                    b = bq.pop_front();
                    chk("burst_addr", {224'd0, burst_addr}, {224'd0, b.addr});
                    chk("burst_dir_wr", {255'd0, burst_write}, {255'd0, b.wr});
                end
            end
            if (line_resp) begin
                if (lq.size() == 0) chk("unexpected_line_resp", 256'd1, 256'd0);
                else begin
                    line_t l;
                    l = lq.pop_front();
                    chk("line_rdata", line_rdata, l.rdata);
                    chk("busy_in_done", {255'd0, busy}, 256'd1);
                    if (l.cyc >= 0) chk("resp_latency", 256'(cyc), 256'(l.cyc));
                end
            end
        end
    end

    // ---------------- pmem model ----------------
    int           pm_gap [4] = '{0, 0, 0, 0};
    int           pm_idx = 0;
    int           pm_cnt = 0;
    int           pm_start = 0;
    logic [255:0] pm_line = '0;
    logic         spur = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!rst_n || !(burst_read || burst_write)) begin
            pm_idx = 0; pm_cnt = 0;
            burst_resp = spur;
            burst_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        end else if (pm_idx < 4 && pm_cnt < pm_gap[pm_idx]) begin
            burst_resp = 1'b0;
            pm_cnt++;
        end else if (pm_idx < 4) begin
            burst_resp = 1'b1;
            burst_rdata = burst_read ? pm_line[((pm_start + pm_idx) % 4) * 64 +: 64]
                                     : 64'hDEAD_BEEF_0BAD_F00D;
            pm_idx++;
            pm_cnt = 0;
        end else begin
            burst_resp = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_resp();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #2;
            if (line_resp) seen = 1'b1;
        end
        if (!seen) chk("line_resp_timeout", 256'd0, 256'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [255:0] ln, input bit zero_wait);
        @(posedge clk); #2;
        pm_line = ln; pm_start = rstart(a);
        push_read(a, ln, zero_wait ? cyc + 5 : -1);
        line_addr = a; line_read = 1'b1;
        wait_resp();
        line_read = 1'b0;
    endtask

    localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] L2 = {64'h0F0E_0D0C_0B0A_0908, 64'h0706_0504_0302_0100,
                                   64'hFFEE_DDCC_BBAA_9988, 64'h7766_5544_3322_1100};
    localparam logic [255:0] W1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [255:0] W3 = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                                   64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};
    localparam logic [255:0] L3 = {64'h8888_0000_8888_0000, 64'h7777_0000_7777_0000,
                                   64'h6666_0000_6666_0000, 64'h5555_0000_5555_0000};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #6;
        chk("rst_busy",        {255'd0, busy}, 256'd0);
        chk("rst_burst_read",  {255'd0, burst_read}, 256'd0);
        chk("rst_burst_write", {255'd0, burst_write}, 256'd0);
        chk("rst_burst_addr",  {224'd0, burst_addr}, 256'd0);
        chk("rst_line_rdata",  line_rdata, 256'd0);
        chk("rst_line_resp",   {255'd0, line_resp}, 256'd0);
        chk("rst_burst_wdata", {192'd0, burst_wdata}, 256'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Zero-wait read at 0x1234
        pm_gap = '{0, 0, 0, 0};
        do_read(32'h0000_1234, L1, 1'b1);

        // Spurious resp in IDLE must not start anything
        @(posedge clk); #2 spur = 1'b1;
        @(posedge clk); #2;
        chk("spur_busy", {255'd0, busy}, 256'd0);
        @(posedge clk); #2;
        chk("spur_busy2", {255'd0, busy}, 256'd0);
        chk("spur_no_resp", {255'd0, line_resp}, 256'd0);
        spur = 1'b0;

        // Read with stalls; line_addr changes mid-burst
        pm_gap = '{1, 1, 1, 1};
        @(posedge clk); #2;
        pm_line = L2; pm_start = rstart(32'h0000_2000);
        push_read(32'h0000_2000, L2, -1);
        line_addr = 32'h0000_2000; line_read = 1'b1;
        repeat (3) @(posedge clk);
        #2 line_addr = 32'hFFFF_FFC0;
        chk("addr_latched", {224'd0, burst_addr}, {224'd0, raddr(32'h0000_2000)});
        wait_resp();
        line_read = 1'b0;

        // Write with stalls 0/3/1/2; line_rdata must stay L2
        pm_gap = '{0, 3, 1, 2};
        @(posedge clk); #2;
        push_write(32'h0000_1234, W1);
        line_addr = 32'h0000_1234; line_wdata = W1; line_write = 1'b1;
        wait_resp();
        line_write = 1'b0;

        // Simultaneous read+write at 0x40: write first, then the held read
        pm_gap = '{0, 0, 0, 0};
        @(posedge clk); #2;
        pm_line = L3; pm_start = rstart(32'h0000_0040);
        push_write(32'h0000_0040, W3);
        push_read(32'h0000_0040, L3, -1);
        line_addr = 32'h0000_0040; line_wdata = W3;
        line_write = 1'b1; line_read = 1'b1;
        wait_resp();
        line_write = 1'b0;
        wait_resp();
        line_read = 1'b0;

        // Read at 0x1238 (beat 3): same line regardless of return order
        do_read(32'h0000_1238, L1, 1'b1);

        // Reset in the middle of a read after two beats
        pm_gap = '{0, 0, 4, 4};
        @(posedge clk); #2;
        pm_line = L2; pm_start = rstart(32'h0000_3000);
        push_read(32'h0000_3000, L2, -1);
        line_addr = 32'h0000_3000; line_read = 1'b1;
        for (int i = 0; i < 50 && pm_idx < 2; i++) @(posedge clk);
        if (pm_idx < 2) chk("two_beats_timeout", 256'd0, 256'd1);
        @(posedge clk); #3;
        rst_n = 1'b0; line_read = 1'b0;
        bq.delete(); lq.delete();
        model_rdata = '0;
        #1;
        chk("mid_rst_busy",        {255'd0, busy}, 256'd0);
        chk("mid_rst_burst_read",  {255'd0, burst_read}, 256'd0);
        chk("mid_rst_burst_addr",  {224'd0, burst_addr}, 256'd0);
        chk("mid_rst_line_rdata",  line_rdata, 256'd0);
        chk("mid_rst_line_resp",   {255'd0, line_resp}, 256'd0);
        #10 rst_n = 1'b1;
        pm_gap = '{0, 0, 0, 0};
        repeat (2) @(posedge clk);
        do_read(32'h0000_3000, L2, 1'b1);

        repeat (4) @(posedge clk);
        chk("beat_queue_drained", 256'(bq.size()), 256'd0);
        chk("line_queue_drained", 256'(lq.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
